// File: rtl/seg_sign_display.sv
// Signed-magnitude to seven-segment display driver: serial double-dabble
// conversion, leading-zero blanking, sign and overflow indication.
module seg_sign_display #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    sign_in,
    input  logic [DATA_WIDTH-1:0]   value_in,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [6:0]              seg_sign,
    output logic [7*NUM_DIGITS-1:0] seg_digits
);

    // Decimal digits needed for the largest DATA_WIDTH-bit magnitude
    function automatic int unsigned bcd_digits_f(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    // Active-low {g,f,e,d,c,b,a} numeral pattern
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    localparam int unsigned BCD_DIGITS = bcd_digits_f(DATA_WIDTH);
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned PAD_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int unsigned PAD_W      = 4 * PAD_DIGITS;
    localparam int unsigned CNT_W      = $clog2(DATA_WIDTH);
    localparam int unsigned SEG_W      = 7 * NUM_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   mag;
    logic                    sgn;
    logic [BCD_W-1:0]        bcd;
    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W-1:0]        bcd_shift;
    logic [PAD_W-1:0]        bcd_pad;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf_c;
    logic                    seen;
    logic [3:0]              dig;
    logic [6:0]              sign_seg_c;
    logic [SEG_W-1:0]        digits_seg_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONVERT;
            CONVERT: if (cnt == CNT_W'(DATA_WIDTH - 1)) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to digits >= 5, then shift in next bit
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign bcd_shift = {bcd_adj[BCD_W-2:0], mag[DATA_WIDTH-1]};
    assign bcd_pad   = PAD_W'(bcd);

    // Display image: overflow dashes, leading-zero blanking, sign
    always_comb begin
        ovf_c        = 1'b0;
        seen         = 1'b0;
        dig          = 4'd0;
        digits_seg_c = '1;
        for (int i = int'(NUM_DIGITS); i < int'(PAD_DIGITS); i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0) ovf_c = 1'b1;
        end
        sign_seg_c = (sgn && (bcd != '0)) ? SEG_DASH : SEG_BLANK;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            dig = bcd_pad[4*k +: 4];
            if (dig != 4'd0) seen = 1'b1;
            if (ovf_c)                digits_seg_c[7*k +: 7] = SEG_DASH;
            else if (seen || k == 0)  digits_seg_c[7*k +: 7] = seg_of(dig);
            else                      digits_seg_c[7*k +: 7] = SEG_BLANK;
        end
    end

    // Capture, conversion datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag        <= '0;
            sgn        <= 1'b0;
            bcd        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            seg_sign   <= SEG_BLANK;
            seg_digits <= '1;
        end else begin
            done <= 1'b0;
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        mag <= value_in;
                        sgn <= sign_in;
                        bcd <= '0;
                        cnt <= '0;
                    end
                end
                CONVERT: begin
                    bcd <= bcd_shift;
                    mag <= {mag[DATA_WIDTH-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                end
                UPDATE: begin
                    overflow   <= ovf_c;
                    seg_sign   <= sign_seg_c;
                    seg_digits <= digits_seg_c;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_sign_display.sv
// Directed bench for seg_sign_display: default build (a) and NUM_DIGITS=3 build (b).
module tb_seg_sign_display;

    logic        clk;
    logic        reset;
    logic        start_a, sign_a;
    logic [15:0] value_a;
    logic        busy_a, done_a, overflow_a;
    logic [6:0]  seg_sign_a;
    logic [34:0] seg_digits_a;
    logic        start_b, sign_b;
    logic [15:0] value_b;
    logic        busy_b, done_b, overflow_b;
    logic [6:0]  seg_sign_b;
    logic [20:0] seg_digits_b;

    int n_checks = 0;
    int n_err    = 0;

    seg_sign_display u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sign_in(sign_a), .value_in(value_a),
        .busy(busy_a), .done(done_a), .overflow(overflow_a),
        .seg_sign(seg_sign_a), .seg_digits(seg_digits_a)
    );

    seg_sign_display #(.DATA_WIDTH(16), .NUM_DIGITS(3)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sign_in(sign_b), .value_in(value_b),
        .busy(busy_b), .done(done_b), .overflow(overflow_b),
        .seg_sign(seg_sign_b), .seg_digits(seg_digits_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start sampled on the next rising edge, returns in the done cycle
    task automatic do_conv(input bit sel, input logic sgn, input logic [15:0] val,
                           output int cyc, output int busy_cnt);
        if (sel) begin start_b = 1'b1; sign_b = sgn; value_b = val; end
        else     begin start_a = 1'b1; sign_a = sgn; value_a = val; end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        cyc      = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sel ? busy_b : busy_a) busy_cnt++;
            if (sel ? done_b : done_a) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        int cyc, bc, ndone, dcyc;
        reset   = 1'b1;
        start_a = 1'b0; sign_a = 1'b0; value_a = '0;
        start_b = 1'b0; sign_b = 1'b0; value_b = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",     64'(busy_a),       64'(0));
        check("rst_done",     64'(done_a),       64'(0));
        check("rst_ovf",      64'(overflow_a),   64'(0));
        check("rst_sign",     64'(seg_sign_a),   64'h7F);
        check("rst_digits",   64'(seg_digits_a), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}));
        check("rst_digits_b", 64'(seg_digits_b), 64'({7'h7F, 7'h7F, 7'h7F}));

        // -1234, start on the first edge after reset release
        reset = 1'b0;
        do_conv(1'b0, 1'b1, 16'd1234, cyc, bc);
        check("n1234_latency", 64'(cyc),          64'(18));
        check("n1234_busy",    64'(bc),           64'(17));
        check("n1234_digits",  64'(seg_digits_a), 64'({7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}));
        check("n1234_sign",    64'(seg_sign_a),   64'h3F);
        check("n1234_ovf",     64'(overflow_a),   64'(0));

        // Negative zero shows plain 0; start right after done
        do_conv(1'b0, 1'b1, 16'd0, cyc, bc);
        check("zero_latency", 64'(cyc),          64'(18));
        check("zero_digits",  64'(seg_digits_a), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
        check("zero_sign",    64'(seg_sign_a),   64'h7F);
        @(negedge clk);
        check("done_pulse",   64'(done_a),       64'(0));

        // 65535 with ignored starts and mid-conversion input changes
        sign_a  = 1'b0;
        value_a = 16'd65535;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        ndone = 0; bc = 0; dcyc = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (busy_a) bc++;
            if (done_a) begin ndone++; dcyc = k; end
            if (k == 4) check("hold_convert", 64'(seg_digits_a),
                              64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
            start_a = (k == 3 || k == 10);
            if (k == 5) begin value_a = 16'd5; sign_a = 1'b1; end
        end
        check("max_ndone",  64'(ndone),        64'(1));
        check("max_dcyc",   64'(dcyc),         64'(18));
        check("max_busy",   64'(bc),           64'(17));
        check("max_digits", 64'(seg_digits_a), 64'({7'h02, 7'h12, 7'h12, 7'h30, 7'h12}));
        check("max_sign",   64'(seg_sign_a),   64'h7F);

        // Show 42, then abort a conversion of 7 with reset
        do_conv(1'b0, 1'b0, 16'd42, cyc, bc);
        check("p42_digits", 64'(seg_digits_a), 64'({7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}));
        sign_a  = 1'b1;
        value_a = 16'd7;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        reset = 1'b1;
        #1;
        check("abort_busy",   64'(busy_a),       64'(0));
        check("abort_done",   64'(done_a),       64'(0));
        check("abort_ovf",    64'(overflow_a),   64'(0));
        check("abort_sign",   64'(seg_sign_a),   64'h7F);
        check("abort_digits", 64'(seg_digits_a), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}));
        repeat (2) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        reset = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        check("abort_no_done", 64'(ndone),       64'(0));
        check("abort_busy2",   64'(busy_a),      64'(0));
        do_conv(1'b0, 1'b1, 16'd7, cyc, bc);
        check("n7_latency", 64'(cyc),          64'(18));
        check("n7_digits",  64'(seg_digits_a), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}));
        check("n7_sign",    64'(seg_sign_a),   64'h3F);

        // Three-digit build: overflow boundary
        do_conv(1'b1, 1'b0, 16'd1000, cyc, bc);
        check("b1000_latency", 64'(cyc),          64'(18));
        check("b1000_ovf",     64'(overflow_b),   64'(1));
        check("b1000_digits",  64'(seg_digits_b), 64'({7'h3F, 7'h3F, 7'h3F}));
        check("b1000_sign",    64'(seg_sign_b),   64'h7F);
        do_conv(1'b1, 1'b0, 16'd999, cyc, bc);
        check("b999_ovf",      64'(overflow_b),   64'(0));
        check("b999_digits",   64'(seg_digits_b), 64'({7'h10, 7'h10, 7'h10}));
        do_conv(1'b1, 1'b1, 16'd1000, cyc, bc);
        check("bn1000_ovf",    64'(overflow_b),   64'(1));
        check("bn1000_sign",   64'(seg_sign_b),   64'h3F);
        check("bn1000_digits", 64'(seg_digits_b), 64'({7'h3F, 7'h3F, 7'h3F}));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
